// File: rtl/can_arb_ctrl.sv
// Per-node CAN arbitration: waits for bus idle, sends SOF + 11-bit ID + RTR, and reports won/lost.
// Define CAN_ARB_BIT_STUFF_EN to insert stuff bits during arbitration.
module can_arb_ctrl #(
  parameter int IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic        bus_in,
  output logic        bus_out,
  output logic        busy,
  output logic        won,
  output logic        lost,
  output logic        bit_err,
  output logic [3:0]  lost_idx
);

  localparam int CW = $clog2(IDLE_BITS + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_BITS);

`ifdef CAN_ARB_BIT_STUFF_EN
  typedef enum logic [2:0] {S_IDLE, S_SOF, S_ID, S_RTR, S_STUFF, S_WON} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SOF, S_ID, S_RTR, S_WON} state_t;
`endif

  state_t        state_reg;
  logic [CW-1:0] idle_cnt_reg;
  logic          bus_idle;
  logic [3:0]    pos_reg;
  logic [3:0]    next_pos;
  logic [15:0]   seq;
  logic          next_bit;
  logic          bit_ok;
  logic          need_stuff;
  logic          go_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_reg <= '0;
    end else if (!bus_in) begin
      idle_cnt_reg <= '0;
    end else if (idle_cnt_reg != IDLE_MAX) begin
      idle_cnt_reg <= idle_cnt_reg + CW'(1);
    end
  end

  assign bus_idle = (idle_cnt_reg == IDLE_MAX);

  // pos_reg: 0 = SOF, 1..11 = id[10]..id[0], 12 = RTR; padding keeps pos 13 in range
  assign seq      = {4'hF, id, rtr};
  assign next_pos = pos_reg + 4'd1;
  assign next_bit = seq[4'd12 - next_pos];
  assign bit_ok   = (bus_in == bus_out);

`ifdef CAN_ARB_BIT_STUFF_EN
  logic [2:0] run_cnt_reg;
  logic       run_val_reg;
  assign need_stuff = (run_cnt_reg == 3'd5);
`else
  assign need_stuff = 1'b0;
`endif

  always_comb begin
    go_next = 1'b0;
    case (state_reg)
      S_SOF, S_ID, S_RTR: go_next = bit_ok && !need_stuff;
`ifdef CAN_ARB_BIT_STUFF_EN
      S_STUFF:            go_next = bit_ok;
`endif
      default:            go_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      pos_reg   <= '0;
      bus_out   <= 1'b1;
      busy      <= 1'b0;
      won       <= 1'b0;
      lost      <= 1'b0;
      bit_err   <= 1'b0;
      lost_idx  <= '0;
`ifdef CAN_ARB_BIT_STUFF_EN
      run_cnt_reg <= '0;
      run_val_reg <= 1'b1;
`endif
    end else begin
      lost    <= 1'b0;
      bit_err <= 1'b0;
      if (go_next) begin
        pos_reg <= next_pos;
        if (next_pos == 4'd13) begin
          state_reg <= S_WON;
          bus_out   <= 1'b1;
          busy      <= 1'b0;
          won       <= 1'b1;
        end else begin
          state_reg <= (next_pos == 4'd12) ? S_RTR : S_ID;
          bus_out   <= next_bit;
`ifdef CAN_ARB_BIT_STUFF_EN
          if (next_bit == run_val_reg) begin
            run_cnt_reg <= run_cnt_reg + 3'd1;
          end else begin
            run_cnt_reg <= 3'd1;
            run_val_reg <= next_bit;
          end
`endif
        end
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (req && bus_idle) begin
              state_reg <= S_SOF;
              bus_out   <= 1'b0;
              busy      <= 1'b1;
              pos_reg   <= '0;
`ifdef CAN_ARB_BIT_STUFF_EN
              run_cnt_reg <= 3'd1;
              run_val_reg <= 1'b0;
`endif
            end
          end
          S_SOF, S_ID, S_RTR: begin
            if (bus_out && !bus_in) begin
              lost      <= 1'b1;
              lost_idx  <= pos_reg - 4'd1;
              state_reg <= S_IDLE;
              bus_out   <= 1'b1;
              busy      <= 1'b0;
            end else if (!bus_out && bus_in) begin
              bit_err   <= 1'b1;
              state_reg <= S_IDLE;
              bus_out   <= 1'b1;
              busy      <= 1'b0;
            end
`ifdef CAN_ARB_BIT_STUFF_EN
            else begin
              state_reg   <= S_STUFF;
              bus_out     <= ~run_val_reg;
              run_cnt_reg <= 3'd1;
              run_val_reg <= ~run_val_reg;
            end
`endif
          end
`ifdef CAN_ARB_BIT_STUFF_EN
          // A stuff bit that passed took the go_next path, so only a mismatch lands here
          S_STUFF: begin
            bit_err   <= 1'b1;
            state_reg <= S_IDLE;
            bus_out   <= 1'b1;
            busy      <= 1'b0;
          end
`endif
          S_WON: begin
            if (!req) begin
              state_reg <= S_IDLE;
              won       <= 1'b0;
            end
          end
          default: begin
            state_reg <= S_IDLE;
            bus_out   <= 1'b1;
            busy      <= 1'b0;
            won       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_arb_ctrl.sv
// Bench for can_arb_ctrl: two nodes on a wired-AND bus, vector table, random arbitration
// against a bit-stream reference model, and hand sequences for idle gating, bit errors and reset.
module tb_can_arb_ctrl;

  localparam int W = 30;
`ifdef CAN_ARB_BIT_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  typedef struct {
    logic [10:0] id0;
    logic        r0;
    logic        q0;
    logic [10:0] id1;
    logic        r1;
    logic        q1;
    logic [1:0]  win;
    logic [3:0]  lidx;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req     [2];
  logic [10:0] id      [2];
  logic        rtr     [2];
  logic        bo      [2];
  logic        busy    [2];
  logic        won     [2];
  logic        lost    [2];
  logic        berr    [2];
  logic [3:0]  lidx    [2];
  logic [3:0]  exp_lidx[2];
  logic        ext;
  logic        force_rec;
  logic        bus;

  logic [31:0] t_bus [2];
  logic [31:0] t_busy[2];
  logic [31:0] t_won [2];
  logic [31:0] t_lost[2];
  logic [31:0] t_berr[2];

  vec_t tbl [7];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  assign bus = force_rec | (bo[0] & bo[1] & ext);

  for (genvar gi = 0; gi < 2; gi++) begin : g_node
    can_arb_ctrl #(.IDLE_BITS(11)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req[gi]),
      .id       (id[gi]),
      .rtr      (rtr[gi]),
      .bus_in   (bus),
      .bus_out  (bo[gi]),
      .busy     (busy[gi]),
      .won      (won[gi]),
      .lost     (lost[gi]),
      .bit_err  (berr[gi]),
      .lost_idx (lidx[gi])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Transmitted stream for {id,rtr}: SOF then 12 arbitration bits, stuff bit after any run of 5
  task automatic build_stream(input logic [11:0] key, output logic [31:0] sb,
                              output int len, output int idx_of [13]);
    int   run;
    logic val;
    logic b;
    sb  = '1;
    len = 0;
    run = 0;
    val = 1'b1;
    for (int q = 0; q < 13; q++) begin
      b = (q == 0) ? 1'b0 : key[12 - q];
      sb[len]   = b;
      idx_of[q] = len;
      len++;
      if (b == val) run++;
      else begin
        run = 1;
        val = b;
      end
      if (STUFF_EN && run == 5) begin
        sb[len] = ~val;
        len++;
        val = ~val;
        run = 1;
      end
    end
  endtask

  task automatic settle(input int cycles);
    req[0] = 1'b0;
    req[1] = 1'b0;
    ext = 1'b1;
    force_rec = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_sof(input int max, output int m);
    m = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (bo[0] == 1'b0) begin
        m = k;
        break;
      end
    end
  endtask

  task automatic run_arb(input logic [10:0] ida, input logic ra, input logic qa,
                         input logic [10:0] idb, input logic rb, input logic qb, input string tag);
    logic [11:0] key [2];
    logic        q   [2];
    logic [11:0] mk;
    logic [31:0] sb;
    int          len;
    int          idx_of [13];
    int          lim;
    int          p;
    logic [31:0] e_bus, e_busy, e_won, e_lost;
    key[0] = {ida, ra};
    key[1] = {idb, rb};
    q[0] = qa;
    q[1] = qb;
    settle(11);
    id[0] = ida; rtr[0] = ra; id[1] = idb; rtr[1] = rb;
    req[0] = qa; req[1] = qb;
    for (int i = 0; i < 2; i++) begin
      t_bus[i] = '0; t_busy[i] = '0; t_won[i] = '0; t_lost[i] = '0; t_berr[i] = '0;
    end
    for (int n = 1; n <= W; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        t_bus[i][n]  = bo[i];
        t_busy[i][n] = busy[i];
        t_won[i][n]  = won[i];
        t_lost[i][n] = lost[i];
        t_berr[i][n] = berr[i];
        if (lost[i]) req[i] = 1'b0;
      end
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);

    mk = 12'hFFF;
    for (int i = 0; i < 2; i++)
      if (q[i] && key[i] < mk) mk = key[i];
    for (int i = 0; i < 2; i++) begin
      e_bus = '0; e_busy = '0; e_won = '0; e_lost = '0; lim = 0;
      build_stream(key[i], sb, len, idx_of);
      if (q[i]) begin
        if (key[i] == mk) begin
          lim = len;
          for (int n = len + 1; n <= W; n++) e_won[n] = 1'b1;
        end else begin
          p = 0;
          while (key[i][11 - p] == mk[11 - p]) p++;
          lim = idx_of[p + 1] + 1;
          e_lost[lim + 1] = 1'b1;
          exp_lidx[i] = p[3:0];
        end
      end
      for (int n = 1; n <= W; n++) begin
        e_bus[n]  = (n <= lim) ? sb[n - 1] : 1'b1;
        e_busy[n] = (n <= lim);
      end
      check($sformatf("%s.n%0d.bus_out", tag, i), t_bus[i], e_bus);
      check($sformatf("%s.n%0d.busy", tag, i), t_busy[i], e_busy);
      check($sformatf("%s.n%0d.won", tag, i), t_won[i], e_won);
      check($sformatf("%s.n%0d.lost", tag, i), t_lost[i], e_lost);
      check($sformatf("%s.n%0d.bit_err", tag, i), t_berr[i], 32'd0);
      check($sformatf("%s.n%0d.lost_idx", tag, i), {28'd0, lidx[i]}, {28'd0, exp_lidx[i]});
      check($sformatf("%s.n%0d.won_release", tag, i), {31'd0, won[i]}, 32'd0);
    end
  endtask

  initial begin
    int          m;
    int          retry;
    logic        lost_seen;
    logic [10:0] ida, idb;
    logic        ra, rb, qa, qb;
    logic [31:0] wv;
    logic [31:0] sb;
    int          len;
    int          idx_of [13];

    tbl[0] = '{11'h7FF, 1'b1, 1'b1, 11'h000, 1'b0, 1'b0, 2'b01, 4'd0};
    tbl[1] = '{11'h123, 1'b0, 1'b1, 11'h124, 1'b0, 1'b1, 2'b01, 4'd8};
    tbl[2] = '{11'h100, 1'b0, 1'b1, 11'h100, 1'b1, 1'b1, 2'b01, 4'd11};
    tbl[3] = '{11'h400, 1'b0, 1'b1, 11'h3FF, 1'b1, 1'b1, 2'b10, 4'd0};
    tbl[4] = '{11'h000, 1'b0, 1'b1, 11'h000, 1'b0, 1'b0, 2'b01, 4'd0};
    tbl[5] = '{11'h2AA, 1'b1, 1'b1, 11'h2AA, 1'b1, 1'b1, 2'b11, 4'd0};
    tbl[6] = '{11'h000, 1'b0, 1'b0, 11'h7FE, 1'b0, 1'b1, 2'b10, 4'd0};

    reset = 1'b0;
    req[0] = 1'b0; req[1] = 1'b0;
    id[0] = '0; id[1] = '0; rtr[0] = 1'b0; rtr[1] = 1'b0;
    ext = 1'b1; force_rec = 1'b0;
    exp_lidx[0] = '0; exp_lidx[1] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset.n%0d.outs", i),
            {26'd0, bo[i], busy[i], won[i], lost[i], berr[i], 1'b0},
            {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      check($sformatf("reset.n%0d.lost_idx", i), {28'd0, lidx[i]}, 32'd0);
    end

    for (int r = 0; r < 7; r++) begin
      run_arb(tbl[r].id0, tbl[r].r0, tbl[r].q0, tbl[r].id1, tbl[r].r1, tbl[r].q1,
              $sformatf("vec%0d", r));
      check($sformatf("vec%0d.winners", r),
            {30'd0, t_won[1] != 0, t_won[0] != 0}, {30'd0, tbl[r].win});
      for (int i = 0; i < 2; i++)
        if (((i == 0) ? tbl[r].q0 : tbl[r].q1) && !tbl[r].win[i])
          check($sformatf("vec%0d.n%0d.table_lost_idx", r, i), {28'd0, lidx[i]}, {28'd0, tbl[r].lidx});
    end

    for (int t = 0; t < 40; t++) begin
      ida = 11'($urandom_range(0, 2047));
      idb = ($urandom_range(0, 1) == 1) ? (ida ^ (11'd1 << $urandom_range(0, 10)))
                                        : 11'($urandom_range(0, 2047));
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      qa = 1'($urandom_range(0, 1));
      qb = 1'($urandom_range(0, 1));
      if (!qa && !qb) qa = 1'b1;
      run_arb(ida, ra, qa, idb, rb, qb, $sformatf("rnd%0d", t));
    end

    // A dominant sample inside the idle window postpones SOF until 11 fresh recessive samples
    settle(11);
    ext = 1'b0;
    @(negedge clk);
    ext = 1'b1; id[0] = 11'h155; rtr[0] = 1'b0; req[0] = 1'b1;
    wait_sof(20, m);
    check("idle_gate.sof_cycle", 32'(m), 32'd12);
    settle(25);

    // Forced recessive during a dominant ID bit
    id[0] = 11'h000; rtr[0] = 1'b0; req[0] = 1'b1;
    retry = -1;
    lost_seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      lost_seen |= lost[0];
      if (n == 5) begin
        check("bit_err.pre_drive", {31'd0, bo[0]}, 32'd0);
        force_rec = 1'b1;
      end
      if (n == 6) begin
        force_rec = 1'b0;
        check("bit_err.pulse", {31'd0, berr[0]}, 32'd1);
        check("bit_err.bus_out", {31'd0, bo[0]}, 32'd1);
        check("bit_err.busy", {31'd0, busy[0]}, 32'd0);
      end
      if (n == 7) check("bit_err.one_cycle", {31'd0, berr[0]}, 32'd0);
      if (n > 6 && retry < 0 && bo[0] == 1'b0) retry = n;
    end
    check("bit_err.retry_sof", 32'(retry), 32'd17);
    check("bit_err.no_lost", {31'd0, lost_seen}, 32'd0);
    check("bit_err.lost_idx_hold", {28'd0, lidx[0]}, {28'd0, exp_lidx[0]});
    settle(25);

    // req dropped during SOF: arbitration completes and won lasts one cycle
    id[0] = 11'h555; rtr[0] = 1'b1; req[0] = 1'b1;
    wv = '0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      wv[n] = won[0];
      if (n == 1) req[0] = 1'b0;
    end
    build_stream({11'h555, 1'b1}, sb, len, idx_of);
    check("won_one_cycle", wv, 32'd1 << (len + 1));
    settle(11);

    // Asynchronous reset in the middle of the ID field
    id[0] = 11'h000; rtr[0] = 1'b0; req[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("async_rst.pre_drive", {31'd0, bo[0]}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("async_rst.bus_out", {31'd0, bo[0]}, 32'd1);
    check("async_rst.busy", {31'd0, busy[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_lidx[0] = '0;
    exp_lidx[1] = '0;
    check("async_rst.lost_idx", {28'd0, lidx[1], lidx[0]}, 32'd0);
    wait_sof(20, m);
    check("async_rst.sof_cycle", 32'(m), 32'd12);
    settle(25);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/can_arb_ctrl.md
# can_arb_ctrl

Per-node CAN arbitration controller for the shared wired-AND bus. It waits for bus idle, then drives SOF, the 11-bit identifier and the RTR bit one bit per clock. Each driven bit is compared against the resolved bus level, and the block reports whether the node won or lost bitwise arbitration. Every CAN controller instance owns one of these blocks. The frame datapath transmits the control, data and CRC fields only after `won` is asserted.

## Interface
- `IDLE_BITS`, default 11: consecutive recessive samples required before the bus counts as idle.
- `clk`, input, 1: bus bit clock; all bus bits are one `clk` period.
- `reset`, input, 1: asynchronous, active-low reset.
- `req`, input, 1: transmit request, level; `id` and `rtr` must be stable while high.
- `id`, input, 11: frame identifier; sent MSB (`id[10]`) first.
- `rtr`, input, 1: RTR bit value.
- `bus_in`, input, 1: resolved wired-AND bus level; 0 is dominant.
- `bus_out`, output, 1: this node's drive onto the bus; 1 is recessive/released.
- `busy`, output, 1: high from the SOF cycle until the block leaves arbitration.
- `won`, output, 1: arbitration won; a level held until `req` falls.
- `lost`, output, 1: one-cycle pulse on arbitration loss.
- `bit_err`, output, 1: one-cycle pulse when the node drove 0 but sampled 1.
- `lost_idx`, output, 4: arbitration bit index at which loss occurred (0 = `id[10]`, 10 = `id[0]`, 11 = RTR); holds until the next loss.

## Operation
- Reset values: `bus_out`=1; `busy`, `won`, `lost` and `bit_err` are 0; `lost_idx`=0; idle counter=0; state is IDLE.
- Idle counter, running in all states:
  - Increments on each `bus_in`=1 sample and saturates at `IDLE_BITS`.
  - Clears on a `bus_in`=0 sample.
  - `bus_idle` = (count == `IDLE_BITS`).
- States: IDLE, SOF, ID, RTR, STUFF (macro-dependent), WON.
- IDLE:
  - `bus_out`=1.
  - If `req` and `bus_idle`, go to SOF.
- SOF: `bus_out`=0.
- ID: 11 cycles, `bus_out`=`id[10-k]`, then RTR.
- RTR: `bus_out`=`rtr`.
- Check at the end of each driven cycle in SOF/ID/RTR, comparing sampled `bus_in` with the current `bus_out`:
  - Drove 1, sampled 0 (ID/RTR only): pulse `lost`, load `lost_idx`, go to IDLE.
  - Drove 0, sampled 1: pulse `bit_err`, go to IDLE.
  - Otherwise, advance.
- RTR completes with a match: go to WON.
- WON:
  - `won`=1, `bus_out`=1 (the datapath now drives the bus).
  - Return to IDLE on the first cycle `req`=0.
- `req` dropping in SOF/ID/RTR is ignored; arbitration completes. If it ends in WON with `req` already low, `won` is high for exactly one cycle.
- The idle counter keeps running through the block's own arbitration. On return to IDLE after `lost`/`bit_err`, a retry therefore waits for `IDLE_BITS` fresh recessive samples.

## Timing
- `bus_out` is registered from the state. `bus_in` is sampled at the posedge that ends the cycle in which the bit was driven.
- Latency, counted from the edge at which IDLE sees `req`&`bus_idle`:
  - SOF is driven in the next cycle.
  - `won` rises 14 cycles after that edge, plus one cycle per stuff bit.
- `lost` and `bit_err` are asserted in the cycle after the offending sample. `bus_out`=1 in that same cycle.
- A node that lost arbitration (`lost`) never drives 0 after the losing bit.
- Asynchronous reset mid-arbitration: `bus_out`=1 immediately; all outputs go to their reset values.

## Configuration
- Macro: `CAN_ARB_BIT_STUFF_EN`.
- When defined, bit stuffing is active:
  - A run counter tracks consecutive identical transmitted bits, starting at SOF (SOF counts as 1).
  - After 5 identical bits, the next cycle enters STUFF and drives the complement.
  - STUFF checks only for mismatch in either direction: any mismatch pulses `bit_err` and goes to IDLE.
  - The stuff bit restarts the run count at 1 with the stuff value.
  - The run counter continues across ID→RTR.
  - A run of 5 completed on the RTR bit inserts a stuff bit before WON.
- When undefined: no STUFF state and no run counter; the bit sequence is exactly 13 bits.

## Test plan
- Reset, then `bus_in`=1 for 11 cycles, `req`=1, `id`=0x7FF, `rtr`=1, macro off → SOF 0, then 12 ones; `won`=1 at +14 cycles; `lost`=`bit_err`=0.
- `id`=0x000, `rtr`=0, macro on → stuff 1s inserted after SOF+id[10:7] and after id[6:2]; `won` at +16 cycles.
- Two instances on a wired-AND bus, `id`=0x123 and 0x124, requested together → 0x124 pulses `lost` with `lost_idx`=8 and releases the bus; 0x123 reaches `won`.
- `bus_in` forced to 1 during an ID bit where `id`=0 → `bit_err` pulse and `bus_out`=1 next cycle; retry only after 11 more recessive samples.
- `req` while `bus_in` shows a 0 within the last 10 samples → no SOF until the idle counter reaches 11.
- `reset` asserted mid-ID → `bus_out`=1 and `busy`=0 asynchronously; after release, the block waits for bus idle before SOF.
